// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter family.
//   - FSM state encodings and the state enum used by the sequencer
//   - channel address constants (client 1..4 -> 00..11)
//   - default grant timeout in WAIT_ACK cycles
package bus_arb_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SELECT   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    SELECT   = ST_SELECT,
    WAIT_ACK = ST_WAIT_ACK,
    RELEASE  = ST_RELEASE
  } arb_state_e;

  localparam logic [1:0] CH1 = 2'b00;
  localparam logic [1:0] CH2 = 2'b01;
  localparam logic [1:0] CH3 = 2'b10;
  localparam logic [1:0] CH4 = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/bus_grant_sequencer_rr_next_client.sv
// Round-robin winner selection (combinational).
// Ports:
//   client_rq   in  request vector, bit i = client i+1
//   last_served in  index of the most recently served client
//   winner      out index of the first requester after last_served (wrapping)
//   valid       out at least one request present
// Rotates the request vector so last_served+1 lands at bit 0, picks the
// lowest set bit, then adds the rotation back. NUMBER_OF_CLIENTS must be a
// power of two so index arithmetic wraps naturally at ADDR_WIDTH bits.
module rr_next_client
  import bus_arb_pkg::*;
#(
  parameter int NUMBER_OF_CLIENTS = 4,
  parameter int ADDR_WIDTH        = 2
) (
  input  logic [NUMBER_OF_CLIENTS-1:0] client_rq,
  input  logic [ADDR_WIDTH-1:0]        last_served,
  output logic [ADDR_WIDTH-1:0]        winner,
  output logic                         valid
);

  logic [ADDR_WIDTH-1:0]        start;
  logic [NUMBER_OF_CLIENTS-1:0] rotated;
  logic [ADDR_WIDTH-1:0]        offset;

  assign start = last_served + 1'b1;

  always_comb begin
    rotated = '0;
    offset  = '0;
    for (int i = 0; i < NUMBER_OF_CLIENTS; i++) begin
      rotated[i] = client_rq[ADDR_WIDTH'(i) + start];
    end
    // descending scan so the lowest set bit wins
    for (int i = NUMBER_OF_CLIENTS - 1; i >= 0; i--) begin
      if (rotated[i]) offset = ADDR_WIDTH'(i);
    end
  end

  assign winner = offset + start;
  assign valid  = |client_rq;

endmodule

// File: rtl/bus_grant_sequencer.sv
// Control FSM for the bus arbiter: picks a requesting client by rotating
// priority, grants it the bus, and holds the grant until the server
// acknowledges or a timeout revokes it.
// Ports:
//   clk                  in  clock, rising edge
//   reset                in  synchronous active-low reset
//   enable               in  permits new arbitration (never aborts a grant)
//   client_rq            in  level requests, bit i = client i+1
//   server_ack           in  one-cycle completion pulse from the server
//   client_gnt           out one-hot grant (registered)
//   server_rq            out request to server (registered)
//   address_to_be_served out index of granted client (registered)
//   timeout_err          out one-cycle pulse when a grant is revoked
//   busy                 out state != IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus free; wait for enable and any request
// SELECT   | one cycle; latch round-robin winner, or fall back if none
// WAIT_ACK | grant held; count cycles until ack or timeout
// RELEASE  | one-cycle turnaround with all grant outputs low
module bus_grant_sequencer
  import bus_arb_pkg::*;
#(
  parameter int NUMBER_OF_CLIENTS = 4,
  parameter int ADDR_WIDTH        = 2,
  parameter int TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUMBER_OF_CLIENTS-1:0] client_rq,
  input  logic                         server_ack,
  output logic [NUMBER_OF_CLIENTS-1:0] client_gnt,
  output logic                         server_rq,
  output logic [ADDR_WIDTH-1:0]        address_to_be_served,
  output logic                         timeout_err,
  output logic                         busy
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0]    LAST_CLIENT   = ADDR_WIDTH'(NUMBER_OF_CLIENTS - 1);
  localparam logic [NUMBER_OF_CLIENTS-1:0] GNT_ONE   = {{(NUMBER_OF_CLIENTS-1){1'b0}}, 1'b1};

  arb_state_e                   state, state_nxt;
  logic [ADDR_WIDTH-1:0]        last_served, last_served_nxt;
  logic [TIMEOUT_WIDTH-1:0]     count, count_nxt;
  logic [NUMBER_OF_CLIENTS-1:0] gnt_nxt;
  logic                         srq_nxt;
  logic [ADDR_WIDTH-1:0]        addr_nxt;
  logic                         terr_nxt;
  logic [ADDR_WIDTH-1:0]        winner;
  logic                         winner_valid;

  rr_next_client #(
    .NUMBER_OF_CLIENTS (NUMBER_OF_CLIENTS),
    .ADDR_WIDTH        (ADDR_WIDTH)
  ) u_rr_next_client (
    .client_rq   (client_rq),
    .last_served (last_served),
    .winner      (winner),
    .valid       (winner_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= IDLE;
      last_served          <= LAST_CLIENT;
      count                <= '0;
      client_gnt           <= '0;
      server_rq            <= 1'b0;
      address_to_be_served <= '0;
      timeout_err          <= 1'b0;
    end else begin
      state                <= state_nxt;
      last_served          <= last_served_nxt;
      count                <= count_nxt;
      client_gnt           <= gnt_nxt;
      server_rq            <= srq_nxt;
      address_to_be_served <= addr_nxt;
      timeout_err          <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    count_nxt       = count;
    gnt_nxt         = client_gnt;
    srq_nxt         = server_rq;
    addr_nxt        = address_to_be_served;
    terr_nxt        = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable && (|client_rq)) state_nxt = SELECT;
      end
      SELECT: begin
        // requests may have dropped since IDLE saw them
        if (winner_valid) begin
          addr_nxt  = winner;
          gnt_nxt   = GNT_ONE << winner;
          srq_nxt   = 1'b1;
          count_nxt = '0;
          state_nxt = WAIT_ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_ACK: begin
        // ack is checked first so it beats a coincident timeout
        if (server_ack || (count == TIMEOUT_LIMIT)) begin
          terr_nxt        = !server_ack;
          last_served_nxt = address_to_be_served;
          gnt_nxt         = '0;
          srq_nxt         = 1'b0;
          addr_nxt        = '0;
          state_nxt       = RELEASE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_grant_sequencer.sv
module tb_bus_grant_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] client_rq;
  logic       server_ack;
  logic [3:0] client_gnt;
  logic       server_rq;
  logic [1:0] address_to_be_served;
  logic       timeout_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  bus_grant_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .client_rq            (client_rq),
    .server_ack           (server_ack),
    .client_gnt           (client_gnt),
    .server_rq            (server_rq),
    .address_to_be_served (address_to_be_served),
    .timeout_err          (timeout_err),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // advance until server_rq rises or the budget runs out
  task automatic wait_grant(input int max_cycles, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      cycles++;
      if (server_rq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle();
    client_rq  = 4'b0000;
    server_ack = 1'b0;
    tick();
    tick();
  endtask

  // pop the expected winner and compare it with the live grant
  task automatic check_grant(input string name, input bit ok);
    logic [1:0] exp_addr;
    logic [3:0] exp_gnt;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_timeout: no grant within budget, got srq=%b required=1", name, server_rq);
    end
    exp_addr = exp_q.pop_front();
    exp_gnt  = 4'b0001 << exp_addr;
    n_cmp++;
    if (address_to_be_served !== exp_addr || client_gnt !== exp_gnt || server_rq !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: got addr=%b gnt=%b srq=%b required addr=%b gnt=%b srq=1",
               name, address_to_be_served, client_gnt, server_rq, exp_addr, exp_gnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; client_rq = 4'b1111; server_ack = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (client_gnt !== 4'b0 || server_rq !== 1'b0 || address_to_be_served !== 2'b0 ||
        timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got gnt=%b srq=%b addr=%b terr=%b busy=%b required all 0",
               client_gnt, server_rq, address_to_be_served, timeout_err, busy);
    end
    client_rq = 4'b0000;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_rotation();
    int cyc;
    bit ok;
    enable = 1'b1;
    client_rq = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back(2'(k % 4));
    for (int k = 0; k < 5; k++) begin
      wait_grant(10, cyc, ok);
      check_grant("rotation", ok);
      n_cmp++;
      if (cyc !== ((k == 0) ? 2 : 3)) begin
        n_bad++;
        $display("FAIL rotation_gap: grant %0d after %0d cycles, required %0d", k, cyc, (k == 0) ? 2 : 3);
      end
      server_ack = 1'b1;
      tick();
      server_ack = 1'b0;
      n_cmp++;
      if (client_gnt !== 4'b0 || server_rq !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL rotation_release: got gnt=%b srq=%b busy=%b required gnt=0000 srq=0 busy=1",
                 client_gnt, server_rq, busy);
      end
    end
  endtask

  task automatic test_single();
    settle();
    client_rq = 4'b0100;
    exp_q.push_back(2'b10);
    tick();
    n_cmp++;
    if (busy !== 1'b1 || server_rq !== 1'b0) begin
      n_bad++;
      $display("FAIL single_select: got busy=%b srq=%b required busy=1 srq=0", busy, server_rq);
    end
    tick();
    check_grant("single", 1'b1);
    tick(); tick(); tick();
    n_cmp++;
    if (client_gnt !== 4'b0100 || server_rq !== 1'b1) begin
      n_bad++;
      $display("FAIL single_hold: got gnt=%b srq=%b required gnt=0100 srq=1", client_gnt, server_rq);
    end
    server_ack = 1'b1;
    client_rq = 4'b0000;
    tick();
    server_ack = 1'b0;
    n_cmp++;
    if (client_gnt !== 4'b0 || server_rq !== 1'b0 || address_to_be_served !== 2'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ack: got gnt=%b srq=%b addr=%b busy=%b required 0000/0/00/1",
               client_gnt, server_rq, address_to_be_served, busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    int early;
    settle();
    client_rq = 4'b0010;
    exp_q.push_back(2'b01);
    wait_grant(10, cyc, ok);
    check_grant("timeout_grant", ok);
    client_rq = 4'b1111;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (timeout_err !== 1'b0 || client_gnt !== 4'b0010) early++;
    end
    n_cmp++;
    if (early !== 0) begin
      n_bad++;
      $display("FAIL timeout_early: %0d bad cycles before limit, required 0", early);
    end
    tick();
    n_cmp++;
    if (timeout_err !== 1'b1 || client_gnt !== 4'b0 || server_rq !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got terr=%b gnt=%b srq=%b required terr=1 gnt=0000 srq=0",
               timeout_err, client_gnt, server_rq);
    end
    tick();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_width: got terr=%b required 0", timeout_err);
    end
    exp_q.push_back(2'b10);
    wait_grant(10, cyc, ok);
    check_grant("timeout_next", ok);
    server_ack = 1'b1;
    tick();
    server_ack = 1'b0;
  endtask

  task automatic test_coincidence();
    int cyc;
    bit ok;
    settle();
    client_rq = 4'b1111;
    exp_q.push_back(2'b11);
    wait_grant(10, cyc, ok);
    check_grant("coinc_grant", ok);
    for (int i = 0; i < 15; i++) tick();
    server_ack = 1'b1;
    tick();
    server_ack = 1'b0;
    n_cmp++;
    if (timeout_err !== 1'b0 || client_gnt !== 4'b0 || server_rq !== 1'b0) begin
      n_bad++;
      $display("FAIL coinc_ack: got terr=%b gnt=%b srq=%b required terr=0 gnt=0000 srq=0",
               timeout_err, client_gnt, server_rq);
    end
    tick();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL coinc_after: got terr=%b required 0", timeout_err);
    end
  endtask

  task automatic test_enable();
    int cyc;
    bit ok;
    int bad;
    enable = 1'b0;
    client_rq = 4'b1111;
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0 || server_rq !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL enable_gate: %0d busy cycles with enable=0, required 0", bad);
    end
    enable = 1'b1;
    exp_q.push_back(2'b00);
    wait_grant(10, cyc, ok);
    check_grant("enable_grant", ok);
    enable = 1'b0;
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (client_gnt !== 4'b0001 || server_rq !== 1'b1) begin
      n_bad++;
      $display("FAIL enable_hold: got gnt=%b srq=%b required gnt=0001 srq=1", client_gnt, server_rq);
    end
    server_ack = 1'b1;
    tick();
    server_ack = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0 || server_rq !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL enable_idle: %0d busy cycles after completion, required 0", bad);
    end
  endtask

  task automatic test_dropped();
    int bad;
    enable = 1'b1;
    client_rq = 4'b0100;
    tick();
    client_rq = 4'b0000;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || client_gnt !== 4'b0 || server_rq !== 1'b0) begin
      n_bad++;
      $display("FAIL dropped_select: got busy=%b gnt=%b srq=%b required 0/0000/0",
               busy, client_gnt, server_rq);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL dropped_idle: %0d busy cycles, required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    enable = 1'b1;
    client_rq = 4'b1111;
    exp_q.push_back(2'b01);
    wait_grant(10, cyc, ok);
    check_grant("rstmid_grant", ok);
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (client_gnt !== 4'b0 || server_rq !== 1'b0 || address_to_be_served !== 2'b0 ||
        timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_abort: got gnt=%b srq=%b addr=%b terr=%b busy=%b required all 0",
               client_gnt, server_rq, address_to_be_served, timeout_err, busy);
    end
    tick();
    reset = 1'b1;
    exp_q.push_back(2'b00);
    wait_grant(10, cyc, ok);
    check_grant("rstmid_first", ok);
    server_ack = 1'b1;
    tick();
    server_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_timeout();
    test_coincidence();
    test_enable();
    test_dropped();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expected grants left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_grant_sequencer.md
Name: bus_grant_sequencer

Overview:
- Control FSM for the 4-client bus arbiter.
- Takes level client requests and picks one by rotating priority.
- Drives a one-hot grant and the served address toward the server.
- Holds the grant until server acknowledge or timeout, then releases the bus and advances priority.

Parameters:
- NUMBER_OF_CLIENTS, 4: number of requesting clients; must be a power of two, at least 2.
- ADDR_WIDTH, 2: width of address_to_be_served, equal to log2(NUMBER_OF_CLIENTS).
- TIMEOUT_CYCLES, 16: WAIT_ACK cycles without server_ack before the grant is revoked.
- TIMEOUT_WIDTH, 5: counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled at posedge clk.
- enable  in  1  permits new arbitration; does not abort an active transaction.
- client_rq  in  NUMBER_OF_CLIENTS  level requests; bit i = client i+1.
- server_ack  in  1  server completion, one-cycle pulse.
- client_gnt  out  NUMBER_OF_CLIENTS  one-hot grant, registered.
- server_rq  out  1  request to server, registered.
- address_to_be_served  out  ADDR_WIDTH  index of granted client (00 = client 1 ... 11 = client 4), registered.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; last_served=NUMBER_OF_CLIENTS-1, so client 1 has first priority.
  - client_gnt=0, server_rq=0, address_to_be_served=0, timeout_err=0, busy=0, timeout counter=0.
  - Reset mid-transaction aborts it immediately; no timeout_err is issued.
- States: IDLE, SELECT, WAIT_ACK, RELEASE.
- IDLE:
  - enable=1 and |client_rq -> SELECT; otherwise stay.
  - server_ack is ignored.
- SELECT (one cycle):
  - Winner = first set bit of client_rq, searching from (last_served+1) mod N upward with wrap.
  - Winner latched: address_to_be_served=winner, client_gnt=1<<winner, server_rq=1, counter cleared -> WAIT_ACK.
  - No request present (dropped) -> IDLE, outputs unchanged at 0.
  - enable is not re-checked in SELECT.
- WAIT_ACK:
  - client_gnt, server_rq and the address are held constant.
  - client_rq changes are ignored.
  - Counter increments every cycle.
  - server_ack=1 -> last_served=winner, outputs cleared on the next edge -> RELEASE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack -> timeout_err=1 for one cycle, last_served=winner (the stalled client loses priority), outputs cleared -> RELEASE.
  - ack in the same cycle as the timeout limit: ack wins, no timeout_err.
- RELEASE (one cycle, bus turnaround):
  - All grant outputs are 0 -> IDLE.
  - Guarantees at least one idle cycle between grants.
- Latency:
  - Request seen in IDLE at edge n -> SELECT at n+1 -> grant/server_rq visible after edge n+2.
  - ack at edge m -> outputs low after edge m+1.
  - Back-to-back service period = 3 cycles + server latency.
- Fairness: with all clients requesting continuously, grant order is 1,2,3,4,1,... with no starvation.
- Grant invariant: client_gnt is one-hot or zero, never multiple bits; server_rq==|client_gnt at all times.
- enable low mid-transaction: the transaction completes normally, then the block idles in IDLE.

Decomposition:
- Shared package bus_arb_pkg:
  - state encoding localparams for IDLE, SELECT, WAIT_ACK, RELEASE;
  - channel address constants CH1..CH4 = 00/01/10/11;
  - default TIMEOUT_CYCLES.
- One combinational sub-module: rr_next_client (inputs client_rq, last_served; outputs winner index and valid).
  - Implemented as a rotate, priority-encode, rotate-back.
  - Reusable by the other arbiter variants.

Test Plan:
- Single request: reset released, enable=1, client_rq=0100 (client 3) -> SELECT next cycle, then client_gnt=0100, address=10, server_rq=1; ack after 3 cycles -> outputs 0 next cycle, busy low after RELEASE.
- Rotation: client_rq=1111 held, ack 1 cycle after each grant -> addresses 00,01,10,11,00 in order, with one RELEASE cycle between each grant.
- Timeout: grant client 2 (address 01), no ack -> timeout_err pulses exactly once 16 cycles after the grant, outputs clear, next grant with 1111 pending goes to client 3 (address 10).
- Ack/timeout coincidence: ack asserted in the 16th WAIT_ACK cycle -> timeout_err stays 0, normal release.
- Enable gating: enable=0 with client_rq=1111 -> busy stays 0 for 20 cycles. Then drop enable during WAIT_ACK -> grant held until ack, then IDLE with no new grant.
- Reset mid-operation: reset=0 during WAIT_ACK -> next edge all outputs 0, state IDLE. On re-enable with client_rq=1111 -> first grant to client 1 (address 00).
